md_sched: RTL and testbench
===========================

// Module: md_sched
// PURPOSE
//  E-stage multiply/divide scheduler. Owns the HI/LO resource for mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
//  Sequences multi-cycle operations with a busy counter.
//  Raises md_stall to HazardCtrl so that any D-stage MD instruction waits while the unit is occupied.
//  Provides HI/LO read data to the E-stage reg_wd mux.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (and madd/maddu when enabled)
//  DIV_LAT   10  busy cycles for div/divu
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-low (0 = reset)
//  e_md_op    in   4   E-stage MD opcode, `MD_* from constants.v; `MD_NONE when not MD
//  e_md_valid in   1   E-stage instruction is real; 0 means bubble or flushed
//  e_rs       in   32  forwarded rs value (fwd E mux output)
//  e_rt       in   32  forwarded rt value
//  d_is_md    in   1   D-stage instruction is any MD-class op, including mf/mt
//  md_busy    out  1   unit is executing a multi-cycle op
//  md_stall   out  1   stall request into HazardCtrl
//  md_rdata   out  32  HI for `MD_MFHI, LO for `MD_MFLO, otherwise 0
//  md_hi      out  32  architectural HI
//  md_lo      out  32  architectural LO
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge):
//    - state=IDLE; cnt=0; md_busy=0; md_hi=0; md_lo=0.
//    - Any in-flight op is aborted and its result discarded.
//  - start = e_md_valid & e_md_op in {MULT,MULTU,DIV,DIVU[,MADD,MADDU]} & state==IDLE.
//  - Start cycle:
//    - Result computed combinationally from e_rs/e_rt and latched into pend_hi/pend_lo.
//    - Signed ops use $signed, 64-bit product.
//    - div: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//    - Next: state=BUSY, cnt = LAT-1.
//  - BUSY:
//    - md_busy=1; cnt decrements each cycle.
//    - On the edge where cnt==0: HI/LO <= pend; state=IDLE.
//    - Timing: md_busy is high for exactly LAT cycles, starting the cycle after start.
//    - New HI/LO are visible on the first cycle after md_busy falls.
//  - Divide by zero (divisor==0): runs the full DIV_LAT busy period; HI/LO are left unchanged at completion.
//  - mthi/mtlo: accepted only in IDLE with e_md_valid; HI or LO <= e_rs at the next edge.
//  - mfhi/mflo: md_rdata is combinational from the current HI/LO, with no internal bypass.
//  - Any MD op presented while BUSY is ignored. HazardCtrl stalling guarantees this cannot occur.
//  - md_stall = d_is_md & (md_busy | start). Combinational; never asserted by a non-MD D instruction.
//  - Simultaneous mtlo in E and completion at the same edge cannot occur, because IDLE is required for mt.
//  - md_hi/md_lo change only at: completion, mt*, reset.
// CONFIGURATION
//  - Macro MD_SCHED_MADD_EN defined:
//    - Adds `MD_MADD and `MD_MADDU.
//    - {HI,LO} <= {HI,LO} + rs*rt, signed or unsigned, 64-bit wraparound.
//    - The accumulate base is the HI/LO value at the start cycle.
//    - Latency MULT_LAT.
//  - Macro undefined: those opcodes are treated as `MD_NONE (no start, no stall contribution).
// STRUCTURE
//  - `MD_* opcode encodings (4-bit) and MD-class decode belong in constants.v, shared with Controller.
//  - Controller emits e_md_op per stage.
//  - No sub-module: the 64-bit arithmetic is one combinational block, and cnt/state form a 2-state FSM in this file.
// TESTING
//  1. mult rs=3, rt=0xFFFFFFFE -> md_busy high 5 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. divu 7/2 -> md_busy 10 cycles -> LO=3, HI=1.
//     div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  3. mtlo 0x1234; div 5/0 -> busy 10 cycles -> LO stays 0x1234, HI stays prior value.
//  4. mult start, then d_is_md=1 with mflo held in D -> md_stall=1 on the start cycle and all 5 busy cycles.
//     Then 0 -> mflo reads the new LO.
//     d_is_md=0 (add) during busy -> md_stall=0.
//  5. reset=0 on busy cycle 3 of div -> next cycle md_busy=0, HI=LO=0; a later mult completes normally.
//  6. (MD_SCHED_MADD_EN) HI=0, LO=0xFFFFFFFF; maddu 1*1 -> HI=1, LO=0.
//     Without the macro -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared MD opcode encodings and scheduler state type.
// Imported by md_sched and by the Controller that drives e_md_op.
package md_sched_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler owning the HI/LO pair.
// Ports: clk, reset (sync, active-low), e_md_op/e_md_valid/e_rs/e_rt (E-stage op),
//   d_is_md (D-stage MD-class flag), md_busy, md_stall, md_rdata, md_hi, md_lo.
// Optional: define MD_SCHED_MADD_EN to add madd/maddu (accumulate into HI/LO).
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_md_op,
    input  logic        e_md_valid,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_md,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    md_state_t   state;
    logic [CW-1:0] cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic        is_mul;
    logic        is_div;
    logic        is_sgn;
    logic        start;

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] prod;
    logic [63:0] mul_res;

    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

`ifdef MD_SCHED_MADD_EN
    logic        is_acc;
`endif

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_sgn = 1'b0;
`ifdef MD_SCHED_MADD_EN
        is_acc = 1'b0;
`endif
        case (e_md_op)
            MD_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            MD_MULTU: begin is_mul = 1'b1; end
            MD_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            MD_DIVU:  begin is_div = 1'b1; end
`ifdef MD_SCHED_MADD_EN
            MD_MADD:  begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; end
            MD_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // Extending to 64 bits first makes the low 64 bits of one unsigned
    // multiply correct for both signed and unsigned operands.
    always_comb begin
        op_a = is_sgn ? {{32{e_rs[31]}}, e_rs} : {32'b0, e_rs};
        op_b = is_sgn ? {{32{e_rt[31]}}, e_rt} : {32'b0, e_rt};
        prod = op_a * op_b;
`ifdef MD_SCHED_MADD_EN
        mul_res = is_acc ? ({md_hi, md_lo} + prod) : prod;
`else
        mul_res = prod;
`endif
    end

    // Sign-magnitude divide: avoids the signed MIN/-1 corner of a native
    // signed divider and gives truncation toward zero directly.
    always_comb begin
        a_neg    = is_sgn & e_rs[31];
        b_neg    = is_sgn & e_rt[31];
        div_zero = (e_rt == 32'd0);
        a_mag    = a_neg ? (32'd0 - e_rs) : e_rs;
        b_mag    = b_neg ? (32'd0 - e_rt) : e_rt;
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    assign start    = e_md_valid & (is_mul | is_div) & (state == ST_IDLE);
    assign md_stall = d_is_md & (md_busy | start);

    always_comb begin
        md_rdata = 32'd0;
        case (e_md_op)
            MD_MFHI: md_rdata = md_hi;
            MD_MFLO: md_rdata = md_lo;
            default: md_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_hi   <= 32'd0;
            md_lo   <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_BUSY;
                        md_busy <= 1'b1;
                        cnt     <= is_div ? CW'(DIV_LAT - 1)
                                          : CW'(MULT_LAT - 1);
                        pend_hi <= is_div ? rem : mul_res[63:32];
                        pend_lo <= is_div ? quo : mul_res[31:0];
                        // divide by zero still occupies the unit but keeps HI/LO
                        pend_wr <= ~(is_div & div_zero);
                    end else if (e_md_valid && e_md_op == MD_MTHI) begin
                        md_hi <= e_rs;
                    end else if (e_md_valid && e_md_op == MD_MTLO) begin
                        md_lo <= e_rs;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state   <= ST_IDLE;
                        md_busy <= 1'b0;
                        if (pend_wr) begin
                            md_hi <= pend_hi;
                            md_lo <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed table, corner sequences,
// and randomized traffic against a cycle-count reference model.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  e_md_op;
    logic        e_md_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_is_md;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk),
        .reset(reset),
        .e_md_op(e_md_op),
        .e_md_valid(e_md_valid),
        .e_rs(e_rs),
        .e_rt(e_rt),
        .d_is_md(d_is_md),
        .md_busy(md_busy),
        .md_stall(md_stall),
        .md_rdata(md_rdata),
        .md_hi(md_hi),
        .md_lo(md_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model: remaining busy cycles plus pending result
    int          m_rem;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pwr;

    // values sampled from the DUT in the most recent cycle
    logic        s_busy, s_stall;
    logic [31:0] s_rdata, s_hi, s_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int op_lat(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: return MULT_LAT;
            MD_DIV, MD_DIVU:   return DIV_LAT;
`ifdef MD_SCHED_MADD_EN
            MD_MADD, MD_MADDU: return MULT_LAT;
`endif
            default:           return 0;
        endcase
    endfunction

    task automatic model_start(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p = 64'd0;
        m_pwr = 1'b1;
        case (op)
            MD_MULT:  p = sa * sb;
            MD_MULTU: p = ua * ub;
            MD_MADD:  p = {m_hi, m_lo} + 64'(sa * sb);
            MD_MADDU: p = {m_hi, m_lo} + ua * ub;
            MD_DIV: begin
                if (b == 32'd0) m_pwr = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) m_pwr = 1'b0;
                else p = {a % b, a / b};
            end
            default: ;
        endcase
        m_phi = p[63:32];
        m_plo = p[31:0];
    endtask

    task automatic cyc(input logic r, input logic [3:0] op, input logic v,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic dm);
        int          lat;
        bit          st;
        logic [31:0] rd;
        @(negedge clk);
        reset = r;
        e_md_op = op;
        e_md_valid = v;
        e_rs = a;
        e_rt = b;
        d_is_md = dm;
        #1;
        lat = op_lat(op);
        st = v && lat > 0 && m_rem == 0;
        rd = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
        s_busy = md_busy;
        s_stall = md_stall;
        s_rdata = md_rdata;
        s_hi = md_hi;
        s_lo = md_lo;
        chk("busy", {31'b0, md_busy}, {31'b0, m_rem > 0});
        chk("stall", {31'b0, md_stall}, {31'b0, dm && (m_rem > 0 || st)});
        chk("rdata", md_rdata, rd);
        chk("hi", md_hi, m_hi);
        chk("lo", md_lo, m_lo);
        @(posedge clk);
        if (!r) begin
            m_rem = 0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            m_rem = lat;
            model_start(op, a, b);
        end else if (v && op == MD_MTHI) begin
            m_hi = a;
        end else if (v && op == MD_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic idle(input logic dm);
        cyc(1'b1, MD_NONE, 1'b0, 32'd0, 32'd0, dm);
    endtask

    initial begin
        int n;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b0;
        e_md_op = MD_NONE;
        e_md_valid = 1'b0;
        e_rs = 32'd0;
        e_rt = 32'd0;
        d_is_md = 1'b0;
        m_rem = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_phi = 32'd0;
        m_plo = 32'd0;
        m_pwr = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        idle(1'b0);
        chk("rst_busy", {31'b0, s_busy}, 32'd0);
        chk("rst_hi", s_hi, 32'd0);
        chk("rst_lo", s_lo, 32'd0);

        tab.push_back('{MD_MTHI,  32'hAAAA5555, 32'd0, 0, 32'hAAAA5555, 32'd0});
        tab.push_back('{MD_MULT,  32'd3, 32'hFFFFFFFE, 5, 32'hFFFFFFFF, 32'hFFFFFFFA});
        tab.push_back('{MD_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3});
        tab.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
        tab.push_back('{MD_MTLO,  32'h1234, 32'd0, 0, 32'hFFFFFFFF, 32'h1234});
        tab.push_back('{MD_DIV,   32'd5, 32'd0, 10, 32'hFFFFFFFF, 32'h1234});
        tab.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'd1});
        tab.push_back('{MD_DIV,   32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD});
        tab.push_back('{MD_MTHI,  32'd0, 32'd0, 0, 32'd0, 32'hFFFFFFFD});
        tab.push_back('{MD_MTLO,  32'hFFFFFFFF, 32'd0, 0, 32'd0, 32'hFFFFFFFF});
`ifdef MD_SCHED_MADD_EN
        tab.push_back('{MD_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0});
`else
        tab.push_back('{MD_MADDU, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF});
`endif

        foreach (tab[i]) begin
            cyc(1'b1, tab[i].op, 1'b1, tab[i].rs, tab[i].rt, 1'b1);
            chk("tab_start_stall", {31'b0, s_stall}, {31'b0, tab[i].lat > 0});
            n = 0;
            for (int k = 0; k < 20; k++) begin
                idle(1'b1);
                if (!s_busy) break;
                n++;
            end
            chk($sformatf("tab%0d_lat", i), n, tab[i].lat);
            chk($sformatf("tab%0d_hi", i), s_hi, tab[i].hi);
            chk($sformatf("tab%0d_lo", i), s_lo, tab[i].lo);
            cyc(1'b1, MD_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
            chk($sformatf("tab%0d_mflo", i), s_rdata, tab[i].lo);
        end

        // stall held for start + busy cycles, dropped for non-MD D op
        cyc(1'b1, MD_MULT, 1'b1, 32'd2, 32'd3, 1'b1);
        chk("t4_start_stall", {31'b0, s_stall}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("t4_busy_stall", {31'b0, s_stall}, 32'd1);
        end
        idle(1'b0);
        chk("t4_add_busy", {31'b0, s_busy}, 32'd1);
        chk("t4_add_stall", {31'b0, s_stall}, 32'd0);
        cyc(1'b1, MD_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
        chk("t4_mflo", s_rdata, 32'd6);
        chk("t4_idle_busy", {31'b0, s_busy}, 32'd0);

        // reset on busy cycle 3 of a divide
        cyc(1'b1, MD_DIVU, 1'b1, 32'd100, 32'd7, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b0, MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("t5_busy_before", {31'b0, s_busy}, 32'd1);
        idle(1'b0);
        chk("t5_busy", {31'b0, s_busy}, 32'd0);
        chk("t5_hi", s_hi, 32'd0);
        chk("t5_lo", s_lo, 32'd0);
        cyc(1'b1, MD_MULT, 1'b1, 32'd4, 32'd5, 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1'b0);
            if (!s_busy) break;
            n++;
        end
        chk("t5_lat", n, MULT_LAT);
        chk("t5_after_lo", s_lo, 32'd20);
        chk("t5_after_hi", s_hi, 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
                default: rb = $urandom;
            endcase
            // skip the one signed-divide overflow case, whose result is unspecified
            if (rop == MD_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF)
                rb = 32'd3;
            cyc(($urandom_range(0, 79) != 0), rop, ($urandom_range(0, 3) != 0),
                ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
